// File: rtl/johnson_pkg.sv
// Shared Johnson-code helpers and checker FSM state type, used by the
// counter stage, this checker and their benches.
package johnson_pkg;

  // Working width of the helpers; callers zero-extend codes up to it.
  localparam int JS_W = 16;

  typedef enum logic [0:0] {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } js_state_t;

  // Successor of an n-bit Johnson code: shift left, feed back inverted MSB.
  function automatic logic [JS_W-1:0] js_next(input logic [JS_W-1:0] s, input int n);
    logic [JS_W-1:0] r;
    r = {JS_W{1'b0}};
    for (int i = 1; i < JS_W; i++) begin
      r[i] = (i < n) ? s[i-1] : 1'b0;
    end
    for (int i = 0; i < JS_W; i++) begin
      if (i == n - 1) r[0] = ~s[i];
    end
    return r;
  endfunction

  // Legal codes have at most one bit transition across the n-bit word.
  function automatic logic js_is_legal(input logic [JS_W-1:0] s, input int n);
    int edges;
    edges = 0;
    for (int i = 0; i < JS_W - 1; i++) begin
      if ((i < n - 1) && (s[i] != s[i+1])) edges++;
    end
    return (edges <= 1);
  endfunction

  function automatic logic [7:0] js_to_phase(input logic [JS_W-1:0] s, input int n);
    logic [7:0] pc;
    pc = 8'd0;
    for (int i = 0; i < JS_W; i++) begin
      if (i < n) pc = pc + {7'd0, s[i]};
    end
    return ((s == {JS_W{1'b0}}) || s[0]) ? pc : (8'(2 * n) - pc);
  endfunction

endpackage

// File: rtl/johnson_seq_checker_decode.sv
// Combinational legality check and binary phase map for one Johnson code.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]           st,
  output logic                   legal,
  output logic [$clog2(2*N)-1:0] phase
);

  localparam int PH_W = $clog2(2 * N);

  // Pure decode of the incoming code.
  always_comb begin
    legal = js_is_legal(JS_W'(st), N);
    phase = PH_W'(js_to_phase(JS_W'(st), N));
  end

endmodule

// File: rtl/johnson_seq_checker.sv
// Johnson counter sequence checker: acquires, tracks, counts revolutions, flags corruption.
// Optional macro JSC_ERR_CNT_EN adds a saturating seq_err counter output err_cnt.
module johnson_seq_checker
  import johnson_pkg::*;
#(
  parameter int N        = 5,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N-1:0]           st_in,
  output logic [$clog2(2*N)-1:0] phase,
  output logic                   phase_vld,
  output logic                   locked,
  output logic                   rev_tick,
  output logic [CNT_W-1:0]       rev_cnt,
  output logic                   seq_err,
  output logic                   err_sticky
`ifdef JSC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]       err_cnt
`endif
);

  localparam int PH_W = $clog2(2 * N);
  localparam int LK_W = $clog2(LOCK_CNT + 1);

  js_state_t       state_r;
  logic [N-1:0]    prev_r;
  logic [LK_W-1:0] lock_cnt_r;
  logic [LK_W-1:0] lock_nxt_s;
  logic            legal_s;
  logic [PH_W-1:0] phase_s;
  logic            acq_s;
  logic            adv_s;
  logic            err_s;

  johnson_decode #(.N(N)) u_decode (
    .st    (st_in),
    .legal (legal_s),
    .phase (phase_s)
  );

  // Classify the current sample; a repeat of prev while tracking is a stall (no flag set).
  always_comb begin
    acq_s = 1'b0;
    adv_s = 1'b0;
    err_s = 1'b0;
    if (en) begin
      case (state_r)
        ACQ: begin
          if (legal_s) acq_s = 1'b1;
          else         err_s = 1'b1;
        end
        TRACK: begin
          if (st_in == prev_r)                                     acq_s = 1'b0;
          else if (js_next(JS_W'(prev_r), N) == JS_W'(st_in))      adv_s = 1'b1;
          else                                                     err_s = 1'b1;
        end
        default: err_s = 1'b1;
      endcase
    end else begin
      adv_s = 1'b0;
    end
    lock_nxt_s = (lock_cnt_r == LK_W'(LOCK_CNT)) ? lock_cnt_r : (lock_cnt_r + LK_W'(1));
  end

  // Checker FSM with all status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ACQ;
      prev_r     <= {N{1'b0}};
      lock_cnt_r <= {LK_W{1'b0}};
      phase      <= {PH_W{1'b0}};
      phase_vld  <= 1'b0;
      locked     <= 1'b0;
      rev_tick   <= 1'b0;
      rev_cnt    <= {CNT_W{1'b0}};
      seq_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      rev_tick <= 1'b0;
      seq_err  <= 1'b0;
      if (acq_s) begin
        state_r    <= TRACK;
        prev_r     <= st_in;
        phase      <= phase_s;
        phase_vld  <= 1'b1;
        lock_cnt_r <= {LK_W{1'b0}};
        locked     <= 1'b0;
      end else if (adv_s) begin
        prev_r     <= st_in;
        phase      <= phase_s;
        lock_cnt_r <= lock_nxt_s;
        locked     <= (lock_nxt_s == LK_W'(LOCK_CNT));
        // Only a tracked wrap counts as a revolution.
        if (phase == PH_W'(2 * N - 1)) begin
          rev_tick <= 1'b1;
          if (rev_cnt != {CNT_W{1'b1}}) rev_cnt <= rev_cnt + CNT_W'(1);
        end
      end else if (err_s) begin
        state_r    <= ACQ;
        seq_err    <= 1'b1;
        err_sticky <= 1'b1;
        phase_vld  <= 1'b0;
        locked     <= 1'b0;
        lock_cnt_r <= {LK_W{1'b0}};
      end
    end
  end

`ifdef JSC_ERR_CNT_EN
  // Saturating count of seq_err pulses, updated on the same edge as seq_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= {CNT_W{1'b0}};
    end else if (err_s && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  // Error counter not built in this configuration.
`endif

endmodule

// File: tb/tb_johnson_seq_checker.sv
// Scoreboard bench for johnson_seq_checker: directed scenarios plus random traffic
// checked against a phase-index reference model.
module tb_johnson_seq_checker;

  localparam int N = 5, CNT_W = 8, LOCK_CNT = 3, P = 2 * N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [N-1:0]     st_in = '0;
  logic [3:0]       phase;
  logic             phase_vld, locked, rev_tick, seq_err, err_sticky;
  logic [CNT_W-1:0] rev_cnt;
`ifdef JSC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  johnson_seq_checker #(.N(N), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .st_in      (st_in),
    .phase      (phase),
    .phase_vld  (phase_vld),
    .locked     (locked),
    .rev_tick   (rev_tick),
    .rev_cnt    (rev_cnt),
    .seq_err    (seq_err),
    .err_sticky (err_sticky)
`ifdef JSC_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ph;
    logic       vld;
    logic       lk;
    logic       tick;
    logic [7:0] rev;
    logic       err;
    logic       stk;
    logic [7:0] ecnt;
  } outs_t;

  outs_t        exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [N-1:0] code_tab[P];

  // Reference model state: position in the 2N-step cycle plus counters.
  int m_track = 0, m_prev = 0, m_phase = 0, m_vld = 0, m_lockc = 0, m_locked = 0;
  int m_rev = 0, m_sticky = 0, m_ecnt = 0;
  int cur = 0;

  function automatic int idx_of(logic [N-1:0] c);
    for (int i = 0; i < P; i++) if (code_tab[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] illegal_code();
    logic [N-1:0] c;
    do c = N'($urandom_range(0, (1 << N) - 1)); while (idx_of(c) >= 0);
    return c;
  endfunction

  task automatic drive(input bit r, input bit e, input logic [N-1:0] c);
    outs_t x;
    int    idx;
    bit    tick, err;
    tick = 1'b0;
    err  = 1'b0;
    @(negedge clk);
    rst = r; en = e; st_in = c;
    if (r) begin
      m_track = 0; m_prev = 0; m_phase = 0; m_vld = 0; m_lockc = 0; m_locked = 0;
      m_rev = 0; m_sticky = 0; m_ecnt = 0;
    end else if (e) begin
      idx = idx_of(c);
      if (m_track == 0) begin
        if (idx >= 0) begin
          m_track = 1; m_prev = idx; m_phase = idx; m_vld = 1; m_lockc = 0; m_locked = 0;
        end else err = 1'b1;
      end else if (idx == m_prev) begin
        m_track = 1;
      end else if (idx >= 0 && idx == (m_prev + 1) % P) begin
        if (m_prev == P - 1) begin
          tick = 1'b1;
          if (m_rev < 255) m_rev++;
        end
        m_prev = idx; m_phase = idx;
        if (m_lockc < LOCK_CNT) m_lockc++;
        m_locked = (m_lockc >= LOCK_CNT) ? 1 : 0;
      end else begin
        err = 1'b1; m_track = 0; m_vld = 0; m_locked = 0; m_lockc = 0;
      end
      if (err) begin
        m_sticky = 1;
        if (m_ecnt < 255) m_ecnt++;
      end
    end
    x.ph = 4'(m_phase); x.vld = m_vld[0]; x.lk = m_locked[0]; x.tick = tick;
    x.rev = 8'(m_rev); x.err = err; x.stk = m_sticky[0];
`ifdef JSC_ERR_CNT_EN
    x.ecnt = 8'(m_ecnt);
`else
    x.ecnt = 8'd0;
`endif
    exp_q.push_back(x);
  endtask

  task automatic go(input int i);
    cur = i;
    drive(1'b0, 1'b1, code_tab[i]);
  endtask

  task automatic adv();
    go((cur + 1) % P);
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    outs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.ph = phase; a.vld = phase_vld; a.lk = locked; a.tick = rev_tick;
        a.rev = rev_cnt; a.err = seq_err; a.stk = err_sticky;
`ifdef JSC_ERR_CNT_EN
        a.ecnt = err_cnt;
`else
        a.ecnt = 8'd0;
`endif
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got ph=%0d vld=%b lk=%b tick=%b rev=%0d err=%b stk=%b ecnt=%0d, want ph=%0d vld=%b lk=%b tick=%b rev=%0d err=%b stk=%b ecnt=%0d",
                   $time, a.ph, a.vld, a.lk, a.tick, a.rev, a.err, a.stk, a.ecnt,
                   e.ph, e.vld, e.lk, e.tick, e.rev, e.err, e.stk, e.ecnt);
        end
      end
    end
  end

  initial begin
    int r;
    // Code table from the definition: p ones from LSB, then ones retreating from the top.
    for (int p = 0; p < P; p++) begin
      if (p <= N) code_tab[p] = N'((1 << p) - 1);
      else        code_tab[p] = N'(((1 << N) - 1) & ~((1 << (p - N)) - 1));
    end

    // Reset dominates en.
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 5'b00101);
    for (int i = 0; i < 4; i++) go(i);
    go(3);

    // Two revolutions with a mid-run stall.
    drive(1'b1, 1'b0, '0);
    go(0);
    for (int k = 1; k <= 25; k++) begin
      adv();
      if (k == 12) repeat (3) go(cur);
    end

    // Illegal code while locked, then re-acquire at 01111.
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) go(i);
    drive(1'b0, 1'b1, 5'b00101);
    go(4);
    repeat (4) adv();

    // Upstream reset mid-revolution, then a skipped step.
    drive(1'b1, 1'b0, '0);
    go(0);
    repeat (17) adv();
    go(0);
    repeat (2) adv();
    go(4);
    repeat (3) adv();

    // Revolution counter saturation, then injected errors.
    drive(1'b1, 1'b0, '0);
    go(0);
    repeat (2600) adv();
    repeat (3) begin
      drive(1'b0, 1'b1, illegal_code());
      adv();
      adv();
    end

    // Random traffic: idle cycles, stalls, jumps, illegal codes, resets.
    repeat (1500) begin
      r = $urandom_range(0, 99);
      if (r < 8)       drive(1'b0, 1'b0, N'($urandom_range(0, (1 << N) - 1)));
      else if (r < 15) go(cur);
      else if (r < 19) go($urandom_range(0, P - 1));
      else if (r < 21) drive(1'b0, 1'b1, illegal_code());
      else if (r < 22) drive(1'b1, r[0], code_tab[cur]);
      else             adv();
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
